// File: rtl/mdu_seq.sv
// Iterative RV64M multiply/divide unit: a shift-add multiplier and a restoring divider
// share one 2*XLEN working register and are sequenced by a five-state FSM.
module mdu_seq #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = 7
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic            word_op,
   input  logic [XLEN-1:0] data_rs1,
   input  logic [XLEN-1:0] data_rs2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);
   localparam int unsigned HW = XLEN / 2;

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;
   state_t state, state_nxt;

   logic [2:0]        op_f3;
   logic              op_word;
   logic [XLEN-1:0]   opa, opb;
   logic [2*XLEN-1:0] work;
   logic [CNT_W-1:0]  cnt;
   logic              neg, spec;

   logic              is_div, a_sgn, b_sgn, a_neg, b_neg;
   logic              unsup, div0, ovf, special;
   logic [XLEN-1:0]   a_ext, b_ext, a_abs, b_abs, most_neg, spec_val;

   always_comb begin
      is_div = op_f3[2];
      a_sgn  = is_div ? ~op_f3[0] : (op_f3[1:0] == 2'b01 || op_f3[1:0] == 2'b10);
      b_sgn  = is_div ? ~op_f3[0] : (op_f3[1:0] == 2'b01);
      if (op_word) begin
         a_ext = {{HW{a_sgn & opa[HW-1]}}, opa[HW-1:0]};
         b_ext = {{HW{b_sgn & opb[HW-1]}}, opb[HW-1:0]};
      end else begin
         a_ext = opa;
         b_ext = opb;
      end
      a_neg    = a_sgn & a_ext[XLEN-1];
      b_neg    = b_sgn & b_ext[XLEN-1];
      a_abs    = a_neg ? -a_ext : a_ext;
      b_abs    = b_neg ? -b_ext : b_ext;
      most_neg = op_word ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      unsup    = op_word & ~is_div & (op_f3[1:0] != 2'b00);
      div0     = is_div & (b_ext == '0);
      ovf      = is_div & ~op_f3[0] & (a_ext == most_neg) & (b_ext == '1);
      special  = unsup | div0 | ovf;
      spec_val = '0;
      if (div0)
         spec_val = op_f3[1] ? a_ext : '1;
      else if (ovf)
         spec_val = op_f3[1] ? '0 : a_ext;
   end

   // One iteration of each algorithm; the divider compares with one extra bit of headroom.
   logic [XLEN:0]     mul_sum;
   logic              div_ge;
   logic [XLEN-1:0]   div_diff;
   logic [2*XLEN-1:0] mul_nxt, div_nxt;

   always_comb begin
      mul_sum  = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, opb} : '0);
      mul_nxt  = {mul_sum, work[XLEN-1:1]};
      div_ge   = work[2*XLEN-1:XLEN-1] >= {1'b0, opb};
      div_diff = work[2*XLEN-2:XLEN-1] - opb;
      div_nxt  = div_ge ? {div_diff, work[XLEN-2:0], 1'b1} : {work[2*XLEN-2:0], 1'b0};
   end

   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo, dv, dv_s, val, fix_val;

   always_comb begin
      prod    = op_word ? {{HW{1'b0}}, work[2*XLEN-1:HW]} : work;
      prod_s  = neg ? -prod : prod;
      quo     = op_word ? {{HW{1'b0}}, work[HW-1:0]} : work[XLEN-1:0];
      dv      = op_f3[1] ? work[2*XLEN-1:XLEN] : quo;
      dv_s    = neg ? -dv : dv;
      if (spec)
         val = work[XLEN-1:0];
      else if (is_div)
         val = dv_s;
      else if (op_f3[1:0] == 2'b00)
         val = prod_s[XLEN-1:0];
      else
         val = prod_s[2*XLEN-1:XLEN];
      fix_val = op_word ? {{HW{val[HW-1]}}, val[HW-1:0]} : val;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Special cases still pass through FIX so they complete in a fixed two cycles.
   always_comb begin
      state_nxt = state;
      in_ready  = (state == S_IDLE);
      busy      = (state != S_IDLE);
      out_valid = (state == S_DONE);
      case (state)
         S_IDLE: if (in_valid && !flush) state_nxt = S_PREP;
         S_PREP: state_nxt = special ? S_FIX : S_CALC;
         S_CALC: if (cnt == '0) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_DONE;
         S_DONE: if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flush && state != S_IDLE)
         state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_f3   <= '0;
         op_word <= 1'b0;
         opa     <= '0;
         opb     <= '0;
         work    <= '0;
         cnt     <= '0;
         neg     <= 1'b0;
         spec    <= 1'b0;
         result  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && !flush) begin
                  op_f3   <= funct3;
                  op_word <= word_op;
                  opa     <= data_rs1;
                  opb     <= data_rs2;
               end
            end
            S_PREP: begin
               spec <= special;
               neg  <= (is_div && op_f3[1]) ? a_neg : (a_neg ^ b_neg);
               cnt  <= op_word ? CNT_W'(HW - 1) : CNT_W'(XLEN - 1);
               opb  <= b_abs;
               if (special)
                  work <= {{XLEN{1'b0}}, spec_val};
               else if (is_div && op_word)
                  work <= {{XLEN{1'b0}}, a_abs[HW-1:0], {HW{1'b0}}};
               else
                  work <= {{XLEN{1'b0}}, a_abs};
            end
            S_CALC: begin
               work <= is_div ? div_nxt : mul_nxt;
               if (cnt != '0)
                  cnt <= cnt - 1'b1;
            end
            S_FIX: begin
               if (!flush)
                  result <= fix_val;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mdu_seq.sv
// Randomized scoreboard bench for mdu_seq: the driver queues expected results from an
// arithmetic reference model, and a monitor checks them as results appear.
module tb_mdu_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  funct3 = '0;
   logic        word_op = 1'b0;
   logic [63:0] data_rs1 = '0;
   logic [63:0] data_rs2 = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] result;
   logic        busy;

   always #5 clk = ~clk;

   mdu_seq #(.XLEN(64), .CNT_W(7)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .funct3(funct3), .word_op(word_op), .data_rs1(data_rs1), .data_rs2(data_rs2),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy)
   );

   typedef struct {
      logic [63:0] val;
      int unsigned lat;
      int unsigned acc;
   } exp_t;

   exp_t        sbq[$];
   exp_t        cur;
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned failures = 0;
   logic        hold_off = 1'b0;
   logic        prev_valid = 1'b0;

   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Reference: RV64M semantics from plain integer arithmetic.
   function automatic logic [63:0] model(input logic [2:0] f, input logic w,
                                         input logic [63:0] a, input logic [63:0] b,
                                         output int unsigned lat);
      logic [127:0] pa, pb, p;
      longint       sa, sb;
      int           x, y;
      logic [31:0]  ux, uy, r32;
      logic [63:0]  r;
      lat = w ? 34 : 66;
      sa = a; sb = b; x = a[31:0]; y = b[31:0]; ux = a[31:0]; uy = b[31:0];
      r = '0; r32 = '0;
      if (w) begin
         case (f)
            3'b000: r32 = ux * uy;
            3'b100: if (y == 0) begin r32 = '1; lat = 2; end
                    else if (ux == 32'h8000_0000 && y == -1) begin r32 = ux; lat = 2; end
                    else r32 = x / y;
            3'b101: if (uy == 0) begin r32 = '1; lat = 2; end else r32 = ux / uy;
            3'b110: if (y == 0) begin r32 = ux; lat = 2; end
                    else if (ux == 32'h8000_0000 && y == -1) begin r32 = '0; lat = 2; end
                    else r32 = x % y;
            3'b111: if (uy == 0) begin r32 = ux; lat = 2; end else r32 = ux % uy;
            default: begin r32 = '0; lat = 2; end
         endcase
         r = {{32{r32[31]}}, r32};
      end else begin
         case (f)
            3'b000: r = a * b;
            3'b001, 3'b010, 3'b011: begin
               pa = (f != 3'b011) ? {{64{a[63]}}, a} : {64'b0, a};
               pb = (f == 3'b001) ? {{64{b[63]}}, b} : {64'b0, b};
               p  = pa * pb;
               r  = p[127:64];
            end
            3'b100: if (b == 0) begin r = '1; lat = 2; end
                    else if (a == MIN64 && b == '1) begin r = a; lat = 2; end
                    else r = sa / sb;
            3'b101: if (b == 0) begin r = '1; lat = 2; end else r = a / b;
            3'b110: if (b == 0) begin r = a; lat = 2; end
                    else if (a == MIN64 && b == '1) begin r = '0; lat = 2; end
                    else r = sa % sb;
            default: if (b == 0) begin r = a; lat = 2; end else r = a % b;
         endcase
      end
      return r;
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return '1;
         2: return MIN64;
         3: return 64'h0000_0000_8000_0000;
         4: return 64'($urandom_range(0, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         out_ready = hold_off ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops the scoreboard on each new result and checks hold/busy behaviour.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            chk1("ready_vs_busy", in_ready, !busy);
            if (out_valid && !prev_valid) begin
               if (sbq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_out_valid: got result %h expected no output", result);
               end else begin
                  cur = sbq.pop_front();
                  chk("result", result, cur.val);
                  chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
               end
            end else if (out_valid) begin
               chk("result_hold", result, cur.val);
            end else if (sbq.size() != 0) begin
               chk1("busy_in_flight", busy, 1'b1);
            end
         end
         prev_valid = out_valid;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 300) begin step(); n++; end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL wait_idle: in_ready got 0 expected 1 within 300 cycles");
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sbq.size() != 0 || !in_ready) && n < 400) begin step(); n++; end
      if (sbq.size() != 0 || !in_ready) begin
         checks++;
         failures++;
         $display("FAIL drain: pending=%0d in_ready=%b expected 0 and 1", sbq.size(), in_ready);
      end
   endtask

   task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input bit track);
      exp_t        e;
      int unsigned l;
      wait_idle();
      funct3 = f; word_op = w; data_rs1 = a; data_rs2 = b; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      if (track) begin
         e.val = model(f, w, a, b, l);
         e.lat = l;
         e.acc = cyc;
         sbq.push_back(e);
      end
   endtask

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog: still running at %0t, expected completion", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk1("reset_in_ready", in_ready, 1'b1);
      chk1("reset_out_valid", out_valid, 1'b0);
      chk1("reset_busy", busy, 1'b0);
      chk("reset_result", result, 64'h0);
      rst_n = 1'b1;
      step();

      issue(3'b000, 1'b0, 64'd7, -64'sd3, 1'b1);
      issue(3'b001, 1'b0, MIN64, MIN64, 1'b1);
      issue(3'b011, 1'b0, '1, '1, 1'b1);
      issue(3'b010, 1'b0, '1, 64'd2, 1'b1);
      issue(3'b100, 1'b0, -64'sd7, 64'd2, 1'b1);
      issue(3'b110, 1'b0, -64'sd7, 64'd2, 1'b1);
      issue(3'b101, 1'b1, 64'hFFFF_FFFF, 64'd2, 1'b1);
      issue(3'b101, 1'b0, 64'h1234, 64'd0, 1'b1);
      issue(3'b110, 1'b0, 64'd5, 64'd0, 1'b1);
      issue(3'b100, 1'b0, MIN64, '1, 1'b1);
      issue(3'b110, 1'b1, 64'h8000_0000, '1, 1'b1);
      issue(3'b001, 1'b1, 64'd9, 64'd9, 1'b1);
      for (int i = 0; i < 40; i++)
         issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pick(), pick(), 1'b1);
      wait_drain();

      // Flush at CALC iteration 10; the cancelled op must never produce output.
      issue(3'b100, 1'b0, 64'd1000, 64'd7, 1'b0);
      repeat (11) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk1("flush_busy", busy, 1'b0);
      chk1("flush_in_ready", in_ready, 1'b1);
      chk1("flush_out_valid", out_valid, 1'b0);
      repeat (80) step();
      issue(3'b010, 1'b0, pick(), pick(), 1'b1);
      wait_drain();

      // Back-pressure: result must hold with out_ready low.
      hold_off = 1'b1;
      issue(3'b100, 1'b0, 64'd1000, 64'd7, 1'b1);
      begin
         int n = 0;
         while (!out_valid && n < 100) begin step(); n++; end
      end
      chk1("bp_out_valid_rise", out_valid, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step();
         chk1("bp_in_ready", in_ready, 1'b0);
         chk1("bp_out_valid", out_valid, 1'b1);
      end
      hold_off = 1'b0;
      wait_drain();

      // Asynchronous reset mid-CALC.
      issue(3'b000, 1'b0, 64'd123, 64'd456, 1'b0);
      repeat (20) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", result, 64'h0);
      step();
      rst_n = 1'b1;
      step();
      issue(3'b111, 1'b1, pick(), pick(), 1'b1);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
